control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the multi-cycle datapath. It steps through fetch (T0–T2) and per-opcode execute states (T3–T7), driving the register-select handshake signals (Gra/Grb/Grc, Rin/Rout/BAout, Cout) into the select-and-encode stage, plus the bus, ALU, memory and PC/IR/MAR/MDR enables. It sits directly upstream of register selection and reads the opcode from the instruction register (IR) output.

## Interface
- Parameters: none; all widths fixed by the ISA (32-bit IR, 5-bit opcode).
- Clocking: one clock; reset is synchronous and active-high.
- clock  in  1  rising-edge system clock
- clear  in  1  synchronous, active-high reset
- IRout  in  32  IR contents; opcode = IRout[31:27]
- mem_ready  in  1  memory done; sampled in T1, ld-T6, st-T7
- PCout, Zlowout, Zhighout, MDRout, Cout  out  1 each  bus drivers
- PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin  out  1 each  register load enables
- IncPC  out  1  ALU computes PC+1 into Z
- Read, Write  out  1 each  memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to register select
- alu_op  out  5  ALU operation code
- run  out  1  high unless in reset or halted
- illegal_op  out  1  one-cycle pulse on an undefined opcode

## Operation
- Moore FSM: every output is a pure decode of the state register plus the latched opcode. No output depends combinationally on `mem_ready`.
- States: S_RST, T0–T7, S_ILL, S_HALT.
- Reset:
  - `clear` high at an edge puts the FSM in S_RST, from any state, including mid-wait.
  - In S_RST all outputs are 0 and `run`=0.
  - Next state is T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold T1 while `mem_ready`=0.
  - T2: MDRout, IRin. The opcode is latched from the bus value at this edge.
- R-type (add, sub, and, or, shr, shra, shl, ror, rol): T3 Grb Rout Yin; T4 Grc Rout Zin with alu_op = opcode; T5 Zlowout Gra Rin.
- addi/andi/ori: same as R-type, except T4 drives Cout instead of Grc Rout. alu_op is ADD/AND/OR respectively.
- ldi: T3 Grb BAout Yin; T4 Cout Zin with alu_op=ADD; T5 Zlowout Gra Rin.
- ld: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin (hold while `mem_ready`=0); T7 MDRout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin with Read=0; T7 Write (hold while `mem_ready`=0).
- neg/not: T3 Grb Rout Zin with alu_op = opcode; T4 Zlowout Gra Rin.
- jr: T3 Gra Rout PCin.
- nop: T2 goes straight to T0.
- halt: T2 goes to S_HALT. All controls are 0 and `run`=0 until `clear`.
- Undefined opcode: T2 goes to S_ILL for one cycle (`illegal_op`=1, no controls), then T0.
- The last state of every sequence returns to T0.
- alu_op is 0 in every state not listed above.

## Timing
- Enables are valid for the whole state cycle; loads take effect at the edge that leaves the state.
- Zero-wait instruction cycle counts (T0 through last state): add 6, addi 6, ld 8, st 8, neg 5, jr 4, nop 3, mul/div 7.
- Each cycle `mem_ready` is low in a wait state adds exactly one cycle. Read/Write stay high for the whole wait.
- If `mem_ready` is already high on entry to a wait state, the FSM leaves that state at the first edge.
- `clear` has priority over `mem_ready` and every transition.

## Configuration
- `CU_MULDIV_EN` defined: mul/div execute as follows.
  - T3 Gra Rout Yin.
  - T4 Grb Rout Zin, alu_op = opcode.
  - T5 Zlowout LOin.
  - T6 Zhighout HIin.
- `CU_MULDIV_EN` undefined: mul/div opcodes take the undefined-opcode path (S_ILL, `illegal_op` pulse). LOin and HIin are tied to 0.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode localparams: ld=0, ldi=1, st=2, add=3, sub=4, and=5, or=6, ror=7, rol=8, shr=9, shra=10, shl=11, addi=12, andi=13, ori=14, mul=15, div=16, neg=17, not=18, jr=20, nop=26, halt=27;
  - the state enum;
  - ALU op codes (ADD=3, AND=5, OR=6).
- Sub-module `op_class_decode`: combinational mapping from opcode to instruction class (RTYPE, IMM, LD, LDI, ST, UNARY, JR, MULDIV, NOP, HALT, ILL). It is instantiated once.

## Test plan
- Reset: assert `clear` 2 cycles, then deassert, with `mem_ready`=1 -> outputs all 0 and `run`=0 during reset; PCout=MARin=IncPC=Zin=1 on the first cycle after.
- add, IR=0x18918000 (R1←R2+R3), `mem_ready`=1 -> T3 Grb/Rout/Yin; T4 Grc/Rout/Zin with alu_op=3; T5 Gra/Rin; T0 on the 7th cycle.
- ld, IR=0x00900055, `mem_ready` low for 3 cycles in T6 -> T3 BAout=1, T4 Cout=1 with alu_op=3; Read held 4 cycles in T6; T7 Gra/Rin/MDRout.
- mul, IR=0x7A280000 -> with the macro: LOin in T5, HIin in T6. Without it: `illegal_op`=1 for one cycle, then T0.
- halt, IR=0xD8000000 -> `run` falls after T2 and stays 0 for 20 cycles; `clear` restarts at T0.
- `clear` asserted during a T1 wait with Read=1 -> Read=0 on the next cycle; state S_RST, then T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-op, state and instruction-class definitions for the
// hardwired control sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [4:0] ALU_ADD = 5'd3;
  localparam logic [4:0] ALU_AND = 5'd5;
  localparam logic [4:0] ALU_OR  = 5'd6;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_ILL, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LD, C_LDI, C_ST, C_UNARY, C_JR, C_MULDIV, C_NOP, C_HALT, C_ILL
  } op_class_t;

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [4:0] imm_alu_op(input logic [4:0] opcode);
    case (opcode)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode -> instruction-class map. mul/div are only a legal
// class when CU_MULDIV_EN is defined.
module op_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = C_ILL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:     op_class = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:   op_class = C_IMM;
      OP_LD:                      op_class = C_LD;
      OP_LDI:                     op_class = C_LDI;
      OP_ST:                      op_class = C_ST;
      OP_NEG, OP_NOT:             op_class = C_UNARY;
      OP_JR:                      op_class = C_JR;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:             op_class = C_MULDIV;
`endif
      OP_NOP:                     op_class = C_NOP;
      OP_HALT:                    op_class = C_HALT;
      default:                    op_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, per-class execute T3-T7.
// Define CU_MULDIV_EN to enable the mul/div execute sequence.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IRout,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        LOin,
  output logic        HIin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);

  state_t    state, state_nxt;
  logic [4:0] op_q;
  op_class_t  cls_q;
  op_class_t  cls_live;

  logic unused_ir;
  assign unused_ir = ^IRout[26:0];

  op_class_decode u_dec (
    .opcode   (IRout[31:27]),
    .op_class (cls_live)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_RST;
      op_q  <= 5'd0;
      cls_q <= C_NOP;
    end else begin
      state <= state_nxt;
      if (state == T2) begin
        op_q  <= IRout[31:27];
        cls_q <= cls_live;
      end
    end
  end

  always_comb begin
    state_nxt = T0;
    case (state)
      S_RST:  state_nxt = T0;
      T0:     state_nxt = T1;
      T1:     state_nxt = mem_ready ? T2 : T1;
      // The class is taken live here since op_q only updates at this edge.
      T2: begin
        case (cls_live)
          C_NOP:   state_nxt = T0;
          C_HALT:  state_nxt = S_HALT;
          C_ILL:   state_nxt = S_ILL;
          default: state_nxt = T3;
        endcase
      end
      T3:     state_nxt = (cls_q == C_JR) ? T0 : T4;
      T4:     state_nxt = (cls_q == C_UNARY) ? T0 : T5;
      T5: begin
        case (cls_q)
          C_LD, C_ST, C_MULDIV: state_nxt = T6;
          default:              state_nxt = T0;
        endcase
      end
      T6: begin
        case (cls_q)
          C_LD:    state_nxt = mem_ready ? T7 : T6;
          C_ST:    state_nxt = T7;
          default: state_nxt = T0;
        endcase
      end
      T7: begin
        if (cls_q == C_ST && !mem_ready) state_nxt = T7;
        else                             state_nxt = T0;
      end
      S_ILL:  state_nxt = T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    LOin = 1'b0; HIin = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_op = 5'd0;
    run = !(state == S_RST || state == S_HALT);
    illegal_op = (state == S_ILL);
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        case (cls_q)
          C_RTYPE, C_IMM:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_UNARY:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q; end
          C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
`ifdef CU_MULDIV_EN
          C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
          default: ;
        endcase
      end
      T4: begin
        case (cls_q)
          C_RTYPE:           begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q; end
          C_IMM:             begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu_op(op_q); end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
          C_UNARY:           begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef CU_MULDIV_EN
          C_MULDIV:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q; end
`endif
          default: ;
        endcase
      end
      T5: begin
        case (cls_q)
          C_RTYPE, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:            begin Zlowout = 1'b1; MARin = 1'b1; end
`ifdef CU_MULDIV_EN
          C_MULDIV:              begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
          default: ;
        endcase
      end
      T6: begin
        case (cls_q)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
`ifdef CU_MULDIV_EN
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
`endif
          default: ;
        endcase
      end
      T7: begin
        case (cls_q)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, several instruction classes,
// memory waits, halt, illegal opcode and clear during a wait.
module tb_control_sequencer;

  logic        clock, clear, mem_ready;
  logic [31:0] IRout;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin;
  logic LOin, HIin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic run, illegal_op;

  int total = 0;
  int bad = 0;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IRout(IRout), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
  );

  localparam logic [21:0] B_PCout   = 22'd1 << 21;
  localparam logic [21:0] B_Zlowout = 22'd1 << 20;
  localparam logic [21:0] B_Zhigh   = 22'd1 << 19;
  localparam logic [21:0] B_MDRout  = 22'd1 << 18;
  localparam logic [21:0] B_Cout    = 22'd1 << 17;
  localparam logic [21:0] B_PCin    = 22'd1 << 16;
  localparam logic [21:0] B_IRin    = 22'd1 << 15;
  localparam logic [21:0] B_MARin   = 22'd1 << 14;
  localparam logic [21:0] B_MDRin   = 22'd1 << 13;
  localparam logic [21:0] B_Yin     = 22'd1 << 12;
  localparam logic [21:0] B_Zin     = 22'd1 << 11;
  localparam logic [21:0] B_LOin    = 22'd1 << 10;
  localparam logic [21:0] B_HIin    = 22'd1 << 9;
  localparam logic [21:0] B_IncPC   = 22'd1 << 8;
  localparam logic [21:0] B_Read    = 22'd1 << 7;
  localparam logic [21:0] B_Write   = 22'd1 << 6;
  localparam logic [21:0] B_Gra     = 22'd1 << 5;
  localparam logic [21:0] B_Grb     = 22'd1 << 4;
  localparam logic [21:0] B_Grc     = 22'd1 << 3;
  localparam logic [21:0] B_Rin     = 22'd1 << 2;
  localparam logic [21:0] B_Rout    = 22'd1 << 1;
  localparam logic [21:0] B_BAout   = 22'd1 << 0;

  localparam logic [21:0] E_T0 = B_PCout | B_MARin | B_IncPC | B_Zin;
  localparam logic [21:0] E_T1 = B_Zlowout | B_PCin | B_Read | B_MDRin;
  localparam logic [21:0] E_T2 = B_MDRout | B_IRin;
  localparam logic [21:0] E_WB = B_Zlowout | B_Gra | B_Rin;

  logic [21:0] ctl;
  assign ctl = {PCout, Zlowout, Zhighout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin,
                LOin, HIin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [21:0] ec, input logic [4:0] ea,
                     input logic er, input logic ei);
    logic [28:0] obs, exp;
    obs = {ctl, alu_op, run, illegal_op};
    exp = {ec, ea, er, ei};
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Called while sitting in T0 with IRout already set; ends in T2.
  task automatic fetch(input string tag);
    step(); chk({tag, "_t1"}, E_T1, 5'd0, 1'b1, 1'b0);
    step(); chk({tag, "_t2"}, E_T2, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    clear = 1'b1; mem_ready = 1'b1; IRout = 32'h0;
    step(); chk("rst_c1", 22'd0, 5'd0, 1'b0, 1'b0);
    step(); chk("rst_c2", 22'd0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
    step(); chk("first_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // add R1 <- R2 + R3
    IRout = 32'h18918000;
    fetch("add");
    step(); chk("add_t3", B_Grb | B_Rout | B_Yin, 5'd0, 1'b1, 1'b0);
    step(); chk("add_t4", B_Grc | B_Rout | B_Zin, 5'd3, 1'b1, 1'b0);
    step(); chk("add_t5", E_WB, 5'd0, 1'b1, 1'b0);
    step(); chk("add_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // ld with three wait cycles in T6
    IRout = 32'h00900055;
    fetch("ld");
    step(); chk("ld_t3", B_Grb | B_BAout | B_Yin, 5'd0, 1'b1, 1'b0);
    step(); chk("ld_t4", B_Cout | B_Zin, 5'd3, 1'b1, 1'b0);
    step(); chk("ld_t5", B_Zlowout | B_MARin, 5'd0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    step(); chk("ld_t6", B_Read | B_MDRin, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("ld_t6_wait", B_Read | B_MDRin, 5'd0, 1'b1, 1'b0);
    end
    mem_ready = 1'b1;
    step(); chk("ld_t7", B_MDRout | B_Gra | B_Rin, 5'd0, 1'b1, 1'b0);
    step(); chk("ld_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // st with one wait cycle in T7
    IRout = 32'h10000000;
    fetch("st");
    step(); chk("st_t3", B_Grb | B_BAout | B_Yin, 5'd0, 1'b1, 1'b0);
    step(); chk("st_t4", B_Cout | B_Zin, 5'd3, 1'b1, 1'b0);
    step(); chk("st_t5", B_Zlowout | B_MARin, 5'd0, 1'b1, 1'b0);
    step(); chk("st_t6", B_Gra | B_Rout | B_MDRin, 5'd0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    step(); chk("st_t7", B_Write, 5'd0, 1'b1, 1'b0);
    step(); chk("st_t7_wait", B_Write, 5'd0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step(); chk("st_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // andi: immediate path with AND op
    IRout = 32'h68000000;
    fetch("andi");
    step(); chk("andi_t3", B_Grb | B_Rout | B_Yin, 5'd0, 1'b1, 1'b0);
    step(); chk("andi_t4", B_Cout | B_Zin, 5'd5, 1'b1, 1'b0);
    step(); chk("andi_t5", E_WB, 5'd0, 1'b1, 1'b0);
    step(); chk("andi_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // neg
    IRout = 32'h88000000;
    fetch("neg");
    step(); chk("neg_t3", B_Grb | B_Rout | B_Zin, 5'd17, 1'b1, 1'b0);
    step(); chk("neg_t4", E_WB, 5'd0, 1'b1, 1'b0);
    step(); chk("neg_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // jr
    IRout = 32'hA0000000;
    fetch("jr");
    step(); chk("jr_t3", B_Gra | B_Rout | B_PCin, 5'd0, 1'b1, 1'b0);
    step(); chk("jr_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // nop
    IRout = 32'hD0000000;
    fetch("nop");
    step(); chk("nop_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // undefined opcode 19
    IRout = 32'h98000000;
    fetch("ill");
    step(); chk("ill_pulse", 22'd0, 5'd0, 1'b1, 1'b1);
    step(); chk("ill_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // mul
    IRout = 32'h7A280000;
    fetch("mul");
`ifdef CU_MULDIV_EN
    step(); chk("mul_t3", B_Gra | B_Rout | B_Yin, 5'd0, 1'b1, 1'b0);
    step(); chk("mul_t4", B_Grb | B_Rout | B_Zin, 5'd15, 1'b1, 1'b0);
    step(); chk("mul_t5", B_Zlowout | B_LOin, 5'd0, 1'b1, 1'b0);
    step(); chk("mul_t6", B_Zhigh | B_HIin, 5'd0, 1'b1, 1'b0);
`else
    step(); chk("mul_ill", 22'd0, 5'd0, 1'b1, 1'b1);
`endif
    step(); chk("mul_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // halt, then restart with clear
    IRout = 32'hD8000000;
    fetch("halt");
    for (int i = 0; i < 20; i++) begin
      step(); chk("halt_hold", 22'd0, 5'd0, 1'b0, 1'b0);
    end
    clear = 1'b1;
    step(); chk("halt_rst", 22'd0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
    step(); chk("halt_t0", E_T0, 5'd0, 1'b1, 1'b0);

    // clear during a T1 memory wait
    IRout = 32'h18918000;
    mem_ready = 1'b0;
    step(); chk("wait_t1", E_T1, 5'd0, 1'b1, 1'b0);
    step(); chk("wait_t1_hold", E_T1, 5'd0, 1'b1, 1'b0);
    clear = 1'b1;
    step(); chk("wait_clear", 22'd0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0; mem_ready = 1'b1;
    step(); chk("wait_t0", E_T0, 5'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
